// File: rtl/seq_num_checker_pkg.sv
// Shared constants and FSM encoding for the MsgSeqNum (tag 34) checker.
package seq_num_checker_pkg;

    // Default width of the host index into the generator counter memory.
    localparam int HOST_ADDR_WIDTH = 4;

    // Classification codes consumed by the session manager.
    localparam logic [2:0] RESULT_IN_ORDER    = 3'd0;
    localparam logic [2:0] RESULT_GAP         = 3'd1;
    localparam logic [2:0] RESULT_LOW         = 3'd2;
    localparam logic [2:0] RESULT_LOW_POSSDUP = 3'd3;
    localparam logic [2:0] RESULT_MALFORMED   = 3'd4;

    // Valid decimal digit range of a value byte.
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACCUM    = 3'd1,
        ST_WAIT_EXP = 3'd2,
        ST_COMPARE  = 3'd3,
        ST_REPORT   = 3'd4
    } state_t;

endpackage

// File: rtl/seq_num_checker_ascii_dec_accum.sv
// ASCII decimal accumulator: turns a stream of value bytes into a binary
// number, counting digits and raising a sticky error on any malformed input.
module ascii_dec_accum
    import seq_num_checker_pkg::*;
#(
    parameter int SEQ_WIDTH  = 32,
    parameter int MAX_DIGITS = 10,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 load,
    input  logic [7:0]           digit,
    input  logic                 last,
    output logic [SEQ_WIDTH-1:0] acc,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 err
);

    // Four spare bits are enough to hold 10 * (2^SEQ_WIDTH - 1) + 9.
    localparam int AW = SEQ_WIDTH + 4;

    logic [AW-1:0] acc_wide;
    logic [AW-1:0] acc_next;
    logic [3:0]    dval;
    logic          is_digit;
    logic          too_many;
    logic          overflow;
    logic          lead_zero;
    logic          zero_val;
    logic          byte_err;

    // Next accumulator value and every reason the incoming byte is unacceptable.
    always_comb begin
        acc_wide  = {4'b0000, acc};
        is_digit  = (digit >= ASCII_ZERO) && (digit <= ASCII_NINE);
        dval      = is_digit ? 4'(digit - ASCII_ZERO) : 4'd0;
        acc_next  = (acc_wide << 3) + (acc_wide << 1) + AW'(dval);
        too_many  = count >= CNT_WIDTH'(MAX_DIGITS);
        overflow  = |acc_next[AW-1:SEQ_WIDTH];
        // A nonzero digit count with a zero accumulator means the value began with '0'.
        lead_zero = (count != '0) && (acc == '0);
        zero_val  = last && (acc_next == '0);
        byte_err  = !is_digit || too_many || overflow || lead_zero || zero_val;
    end

    // Accumulate while clean; once the error flag is set the value freezes
    // but the digit count keeps running (saturating).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc   <= '0;
            count <= '0;
            err   <= 1'b0;
        end else if (clear) begin
            acc   <= '0;
            count <= '0;
            err   <= 1'b0;
        end else if (load) begin
            if (count != '1) begin
                count <= count + CNT_WIDTH'(1);
            end
            if (!err && !byte_err) begin
                acc <= acc_next[SEQ_WIDTH-1:0];
            end else begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_num_checker.sv
// Receive-path MsgSeqNum checker. Parses the ASCII value of tag 34, fetches
// the expected number for the sending host from sequence_generator and
// classifies the message; in-order messages advance the host's counter.
// Handshake: a value byte transfers on a clock edge where digit_valid_i and
// digit_ready_o are both high; digit_ready_o is high only in ACCUM and the
// producer holds digit_i/digit_last_i stable until the transfer.
module seq_num_checker
    import seq_num_checker_pkg::*;
#(
    parameter int SEQ_WIDTH  = 32,
    parameter int MAX_DIGITS = 10,
    parameter int HOST_ADDR  = HOST_ADDR_WIDTH,
    parameter int CNT_WIDTH  = $clog2(MAX_DIGITS + 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [HOST_ADDR-1:0] host_addr_i,
    input  logic                 poss_dup_i,
    input  logic                 digit_valid_i,
    input  logic [7:0]           digit_i,
    input  logic                 digit_last_i,
    output logic                 digit_ready_o,
    output logic                 busy_o,
    output logic                 receive_new_message_o,
    output logic [HOST_ADDR-1:0] received_host_addr_o,
    input  logic [SEQ_WIDTH-1:0] expected_seq_num_i,
    output logic                 update_seq_counter_o,
    output logic [HOST_ADDR-1:0] seq_counter_loc_o,
    output logic [SEQ_WIDTH-1:0] new_seq_num_o,
    output logic                 result_valid_o,
    output logic [2:0]           result_o,
    output logic [SEQ_WIDTH-1:0] received_seq_num_o,
    output state_t               dbg_state_o,
    output logic [CNT_WIDTH-1:0] dbg_digit_cnt_o
);

    state_t                state_q;
    state_t                state_d;
    logic [HOST_ADDR-1:0]  addr_q;
    logic                  rnm_q;
    logic                  rnm_d_q;
    logic [SEQ_WIDTH-1:0]  exp_q;
    logic                  exp_ok_q;
    logic                  pd_q;
    logic                  res_valid_q;
    logic [2:0]            res_q;
    logic                  upd_q;
    logic [HOST_ADDR-1:0]  loc_q;
    logic [SEQ_WIDTH-1:0]  new_q;
    logic [SEQ_WIDTH-1:0]  acc;
    logic                  acc_err;
    logic                  start_accept;
    logic                  digit_accept;
    logic                  last_accept;
    logic                  exp_capture;
    logic [2:0]            cls;

    assign start_accept = start_i && (state_q == ST_IDLE);
    assign digit_accept = digit_valid_i && (state_q == ST_ACCUM);
    assign last_accept  = digit_accept && digit_last_i;
    // Generator answers the cycle after the request pulse; WAIT_EXP always
    // coincides with that cycle but is listed so the capture cannot be missed.
    assign exp_capture  = rnm_d_q || (state_q == ST_WAIT_EXP);

    ascii_dec_accum #(
        .SEQ_WIDTH  (SEQ_WIDTH),
        .MAX_DIGITS (MAX_DIGITS),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_accum (
        .clk   (clk),
        .rst   (rst),
        .clear (start_accept),
        .load  (digit_accept),
        .digit (digit_i),
        .last  (digit_last_i),
        .acc   (acc),
        .count (dbg_digit_cnt_o),
        .err   (acc_err)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; skip WAIT_EXP when the expected value is already in hand.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start_i) state_d = ST_ACCUM;
            ST_ACCUM:    if (last_accept) state_d = (exp_ok_q || rnm_d_q) ? ST_COMPARE : ST_WAIT_EXP;
            ST_WAIT_EXP: state_d = ST_COMPARE;
            ST_COMPARE:  state_d = ST_REPORT;
            ST_REPORT:   state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Classification of the parsed value against the expected one.
    always_comb begin
        cls = RESULT_LOW;
        if (acc_err) begin
            cls = RESULT_MALFORMED;
        end else if (acc == exp_q) begin
            cls = RESULT_IN_ORDER;
        end else if (acc > exp_q) begin
            cls = RESULT_GAP;
        end else if (pd_q) begin
            cls = RESULT_LOW_POSSDUP;
        end
    end

    // Transaction context: host address, generator request pulse, expected value, PossDup.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q   <= '0;
            rnm_q    <= 1'b0;
            rnm_d_q  <= 1'b0;
            exp_q    <= '0;
            exp_ok_q <= 1'b0;
            pd_q     <= 1'b0;
        end else begin
            rnm_q   <= start_accept;
            rnm_d_q <= rnm_q;
            if (start_accept) begin
                addr_q   <= host_addr_i;
                exp_ok_q <= 1'b0;
                pd_q     <= 1'b0;
            end else if (exp_capture) begin
                exp_q    <= expected_seq_num_i;
                exp_ok_q <= 1'b1;
            end
            if (last_accept) begin
                pd_q <= poss_dup_i;
            end
        end
    end

    // Result and counter update, registered out of COMPARE so they show in REPORT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid_q <= 1'b0;
            res_q       <= '0;
            upd_q       <= 1'b0;
            loc_q       <= '0;
            new_q       <= '0;
        end else begin
            res_valid_q <= (state_q == ST_COMPARE);
            upd_q       <= 1'b0;
            loc_q       <= '0;
            new_q       <= '0;
            if (state_q == ST_COMPARE) begin
                res_q <= cls;
                if (cls == RESULT_IN_ORDER) begin
                    upd_q <= 1'b1;
                    loc_q <= addr_q;
                    new_q <= acc + SEQ_WIDTH'(1);
                end
            end
        end
    end

    assign busy_o                = (state_q != ST_IDLE);
    assign digit_ready_o         = (state_q == ST_ACCUM);
    assign receive_new_message_o = rnm_q;
    assign received_host_addr_o  = busy_o ? addr_q : '0;
    assign update_seq_counter_o  = upd_q;
    assign seq_counter_loc_o     = loc_q;
    assign new_seq_num_o         = new_q;
    assign result_valid_o        = res_valid_q;
    assign result_o              = res_q;
    assign received_seq_num_o    = acc;
    assign dbg_state_o           = state_q;

endmodule

// File: tb/tb_seq_num_checker.sv
// Directed and lightly randomised bench for seq_num_checker with a result scoreboard.
module tb_seq_num_checker;
    import seq_num_checker_pkg::*;

    localparam int W = 73;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [3:0]  host_addr_i = '0;
    logic        poss_dup_i = 1'b0;
    logic        digit_valid_i = 1'b0;
    logic [7:0]  digit_i = '0;
    logic        digit_last_i = 1'b0;
    logic        digit_ready_o;
    logic        busy_o;
    logic        receive_new_message_o;
    logic [3:0]  received_host_addr_o;
    logic [31:0] expected_seq_num_i = '0;
    logic        update_seq_counter_o;
    logic [3:0]  seq_counter_loc_o;
    logic [31:0] new_seq_num_o;
    logic        result_valid_o;
    logic [2:0]  result_o;
    logic [31:0] received_seq_num_o;
    state_t      dbg_state;
    logic [3:0]  dbg_cnt;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_results = 0;
    int last_res_cyc = 0;

    seq_num_checker dut (
        .clk                   (clk),
        .rst                   (rst),
        .start_i               (start_i),
        .host_addr_i           (host_addr_i),
        .poss_dup_i            (poss_dup_i),
        .digit_valid_i         (digit_valid_i),
        .digit_i               (digit_i),
        .digit_last_i          (digit_last_i),
        .digit_ready_o         (digit_ready_o),
        .busy_o                (busy_o),
        .receive_new_message_o (receive_new_message_o),
        .received_host_addr_o  (received_host_addr_o),
        .expected_seq_num_i    (expected_seq_num_i),
        .update_seq_counter_o  (update_seq_counter_o),
        .seq_counter_loc_o     (seq_counter_loc_o),
        .new_seq_num_o         (new_seq_num_o),
        .result_valid_o        (result_valid_o),
        .result_o              (result_o),
        .received_seq_num_o    (received_seq_num_o),
        .dbg_state_o           (dbg_state),
        .dbg_digit_cnt_o       (dbg_cnt)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
        end
    endtask

    // Reference: {chk_recv, result, recv, update, loc, new}.
    function automatic logic [W-1:0] model(input string s, input logic [31:0] e,
                                           input logic pd, input logic [3:0] a);
        logic [63:0] v;
        logic        bad;
        logic [2:0]  r;
        logic        upd;
        logic [31:0] nv;
        logic [7:0]  c;
        v = '0;
        bad = (s.len() == 0) || (s.len() > 10);
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (c < 8'h30 || c > 8'h39) bad = 1'b1;
            else v = v * 10 + 64'(c - 8'h30);
            if (i == 0 && s.len() > 1 && c == 8'h30) bad = 1'b1;
        end
        if (v > 64'hFFFF_FFFF || v == 0) bad = 1'b1;
        upd = 1'b0;
        nv = '0;
        if (bad) r = 3'd4;
        else if (v[31:0] == e) begin r = 3'd0; upd = 1'b1; nv = v[31:0] + 32'd1; end
        else if (v[31:0] > e) r = 3'd1;
        else r = pd ? 3'd3 : 3'd2;
        return {~bad, r, v[31:0], upd, a, nv};
    endfunction

    // Scoreboard: compare each result pulse against the oldest expectation.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst === 1'b1) begin
            if (update_seq_counter_o === 1'b1) begin
                chk("upd_with_rnm", receive_new_message_o, 1'b0);
                chk("upd_without_result", result_valid_o, 1'b1);
            end
            if (result_valid_o === 1'b1) begin
                n_results++;
                last_res_cyc = cyc;
                chk("result_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("result_code", result_o, e[71:69]);
                    if (e[72]) chk("recv_value", received_seq_num_o, e[68:37]);
                    chk("update_flag", update_seq_counter_o, e[36]);
                    if (e[36]) begin
                        chk("update_loc", seq_counter_loc_o, e[35:32]);
                        chk("update_new", new_seq_num_o, e[31:0]);
                    end
                end
            end
        end
    end

    task automatic send_txn(input string s, input logic pd, input logic [3:0] a,
                            input int dly, output int s_cyc);
        exp_q.push_back(model(s, expected_seq_num_i, pd, a));
        @(posedge clk); #1;
        start_i = 1'b1;
        host_addr_i = a;
        s_cyc = cyc;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (dly) begin @(posedge clk); #1; end
        for (int i = 0; i < s.len(); i++) begin
            digit_valid_i = 1'b1;
            digit_i = s[i];
            digit_last_i = (i == s.len() - 1);
            poss_dup_i = pd;
            @(posedge clk); #1;
        end
        digit_valid_i = 1'b0;
        digit_last_i = 1'b0;
        poss_dup_i = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy_o !== 1'b0 && k < 30) begin @(posedge clk); #1; k++; end
        chk("idle_timeout", busy_o, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic run(input string s, input logic pd, input logic [3:0] a, input logic [31:0] e);
        int sc;
        expected_seq_num_i = e;
        send_txn(s, pd, a, 1, sc);
        wait_idle();
    endtask

    initial begin
        int sc;
        int nres;
        int v;
        string s;
        logic [31:0] e;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_ready", digit_ready_o, 1'b0);
        chk("rst_state", dbg_state, ST_IDLE);
        chk("rst_result_valid", result_valid_o, 1'b0);
        chk("rst_recv", received_seq_num_o, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Main classifications.
        run("123", 1'b0, 4'd2, 32'd123);
        run("130", 1'b0, 4'd2, 32'd123);
        chk("gap_recv_held", received_seq_num_o, 32'd130);
        run("5", 1'b0, 4'd3, 32'd123);
        run("5", 1'b1, 4'd3, 32'd123);
        run("4294967295", 1'b0, 4'd1, 32'd123);
        run("4294967295", 1'b0, 4'd7, 32'hFFFF_FFFF);

        // Malformed values.
        run("4294967296", 1'b0, 4'd1, 32'd123);
        run("12a", 1'b0, 4'd1, 32'd12);
        run("007", 1'b0, 4'd1, 32'd7);
        run("0", 1'b0, 4'd1, 32'd0);
        run("12345678901", 1'b0, 4'd1, 32'd123);

        // Single digit right after start: WAIT_EXP path, plus an ignored start while busy.
        expected_seq_num_i = 32'd7;
        nres = n_results;
        send_txn("7", 1'b0, 4'd6, 0, sc);
        start_i = 1'b1;
        host_addr_i = 4'd9;
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_idle();
        repeat (4) @(posedge clk);
        #1;
        chk("wait_exp_latency", last_res_cyc, sc + 4);
        chk("busy_start_ignored", n_results - nres, 1);

        // Reset mid-ACCUM.
        expected_seq_num_i = 32'd123;
        @(posedge clk); #1;
        start_i = 1'b1;
        host_addr_i = 4'd5;
        @(posedge clk); #1;
        start_i = 1'b0;
        digit_valid_i = 1'b1;
        digit_i = "1";
        @(posedge clk); #1;
        digit_i = "2";
        @(posedge clk); #1;
        digit_valid_i = 1'b0;
        chk("partial_acc", received_seq_num_o, 32'd12);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy_o, 1'b0);
        chk("mid_rst_ready", digit_ready_o, 1'b0);
        chk("mid_rst_addr", received_host_addr_o, 4'd0);
        chk("mid_rst_recv", received_seq_num_o, 32'd0);
        chk("mid_rst_result", {result_valid_o, update_seq_counter_o, receive_new_message_o, result_o}, 6'd0);
        chk("mid_rst_new", {seq_counter_loc_o, new_seq_num_o}, 36'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        run("123", 1'b0, 4'd2, 32'd123);

        // Random well-formed values against nearby expected numbers.
        for (int i = 0; i < 8; i++) begin
            v = $urandom_range(1, 999999);
            s = $sformatf("%0d", v);
            case ($urandom_range(0, 2))
                0: e = 32'(v);
                1: e = 32'(v) + 32'($urandom_range(1, 100));
                default: e = 32'(v) - 32'($urandom_range(1, v));
            endcase
            expected_seq_num_i = e;
            send_txn(s, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom_range(0, 3), sc);
            wait_idle();
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_num_checker.md
Name: seq_num_checker

Overview:
- Sits directly upstream of sequence_generator on the receive path.
- Consumes the ASCII value bytes of tag 34 (MsgSeqNum) from the received-message parser and converts them to binary.
- Requests the expected sequence number for the sending host, then classifies the message as in-order, gap, low or malformed.
- On in-order, writes the next expected value back to the generator's counter memory; the session manager acts on the result code.

Parameters:
SEQ_WIDTH, 32, binary sequence-number width (matches generator counter memory)
MAX_DIGITS, 10, maximum accepted ASCII digits
HOST_ADDR, `HOST_ADDR_WIDTH, host index width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start_i  in  1  pulse: a tag-34 value begins; accepted only when busy_o=0
host_addr_i  in  HOST_ADDR  sending host, sampled with start_i
poss_dup_i  in  1  PossDupFlag (tag 43 = Y), sampled with the last digit
digit_valid_i  in  1  digit_i holds a value byte
digit_i  in  8  ASCII byte (SOH not delivered)
digit_last_i  in  1  qualifies the final value byte
digit_ready_o  out  1  byte accepted when digit_valid_i & digit_ready_o
busy_o  out  1  high in every state except IDLE
receive_new_message_o  out  1  to generator receive_new_message_i
received_host_addr_o  out  HOST_ADDR  to generator received_host_addr_i
expected_seq_num_i  in  SEQ_WIDTH  from generator expected_seq_num_o (low bits)
update_seq_counter_o  out  1  to generator updateSeqCounter_i
seq_counter_loc_o  out  HOST_ADDR  to generator seqCounterLoc_i
new_seq_num_o  out  SEQ_WIDTH  to generator newSeqNum_i (top level zero-extends)
result_valid_o  out  1  one-cycle pulse
result_o  out  3  classification code
received_seq_num_o  out  SEQ_WIDTH  parsed value, held until the next start

Behaviour:
- Reset: state IDLE. Every output and internal register is 0.
- Reset asserted mid-operation aborts the transaction. No result or update is emitted.

State machine:
- IDLE: busy_o=0, digit_ready_o=0.
  - start_i latches host_addr_i, clears the accumulator, digit count and error flag, then goes to ACCUM.
- ACCUM: digit_ready_o=1.
  - First ACCUM cycle: registered receive_new_message_o=1 for exactly one cycle; received_host_addr_o = latched address, held stable until IDLE.
  - The cycle after that pulse: expected_seq_num_i is captured and exp_ok is set.
  - On an accepted byte with digit_last_i: poss_dup_i is latched. Next state is COMPARE if exp_ok is already set or is set at that same edge, otherwise WAIT_EXP.
- WAIT_EXP: capture expected, then go to COMPARE. digit_ready_o=0.
- COMPARE: register the classification, then go to REPORT.
- REPORT: result_valid_o=1 for one cycle, plus update_seq_counter_o when applicable, then go to IDLE.
- Latency: result_valid_o is high in cycle max(N, S+2)+2, where S = start cycle and N = last-digit cycle.

Accumulation:
- acc_next = acc*10 + (byte - 0x30), computed as (acc<<3)+(acc<<1)+digit at SEQ_WIDTH+4 bits.
- A sticky error flag is set on any of:
  - byte outside 0x30..0x39
  - digit count > MAX_DIGITS
  - acc_next > 2^SEQ_WIDTH-1
  - leading '0' on a multi-digit value
  - final value 0
- After an error, bytes are still consumed until digit_last_i; the accumulator is frozen.

Classification (result codes defined in defines.vh):
- error → MALFORMED=4
- recv == exp → IN_ORDER=0. Pulse update_seq_counter_o with seq_counter_loc_o = latched address and new_seq_num_o = recv+1, wrapping modulo 2^SEQ_WIDTH.
- recv > exp → GAP=1
- recv < exp and poss_dup latched → LOW_POSSDUP=3
- recv < exp otherwise → LOW=2
- Only IN_ORDER produces an update.

Other boundary rules:
- start_i while busy_o=1 is ignored.
- digit_valid_i outside ACCUM is ignored.
- update_seq_counter_o never coincides with receive_new_message_o.

Decomposition:
- defines.vh: RESULT_* codes, ASCII_ZERO/ASCII_NINE, FSM state encodings.
- One sub-module, ascii_dec_accum: clear/load/digit in → acc, digit count, error flag out.

Test Plan:
- exp=123, digits "123", addr=2 → IN_ORDER; update_seq_counter_o=1, seq_counter_loc_o=2, new_seq_num_o=124.
- exp=123, digits "130" → GAP; received_seq_num_o=130; no update.
- exp=123, "5" with poss_dup=0 → LOW; repeat with poss_dup=1 → LOW_POSSDUP.
- "4294967295" → parsed 0xFFFFFFFF. "4294967296", "12a", "007" and "0" → MALFORMED, no update.
- Single-digit "7" on the cycle right after start → WAIT_EXP taken; result_valid_o in cycle S+4. A second start_i while busy is ignored.
- rst low mid-ACCUM after "12" → all outputs 0 immediately. Next transaction "123" → correct IN_ORDER.
